// File: rtl/packet_wrr_arbiter.sv
// Packet-locked weighted round-robin N:1 AXI-Stream arbiter with a zero-latency data path.
// The FSM tracks ownership (IDLE/HOLD/BUSY), per-turn packet credit and the packet's target coordinates.
module packet_wrr_arbiter #(
  parameter int DATA_WIDTH           = 32,
  parameter int ID_WIDTH             = 4,
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int MAX_ROUTERS_X        = 4,
  parameter int MAX_ROUTERS_Y        = 4,
  parameter int LENGTH_WIDTH         = 8,
  parameter int WEIGHT_WIDTH         = 4,
  parameter int FRAMING              = 0,
  parameter int ROUTING_HEADER_ID    = 0,
  localparam int XW = $clog2(MAX_ROUTERS_X),
  localparam int YW = $clog2(MAX_ROUTERS_Y)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [CHANNEL_NUMBER-1:0]              in_tvalid_i,
  input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0]   in_tdata_i,
  input  logic [CHANNEL_NUMBER*ID_WIDTH-1:0]     in_tid_i,
  input  logic [CHANNEL_NUMBER-1:0]              in_tlast_i,
  output logic [CHANNEL_NUMBER-1:0]              in_tready_o,
  output logic                                   out_tvalid_o,
  output logic [DATA_WIDTH-1:0]                  out_tdata_o,
  output logic [ID_WIDTH-1:0]                    out_tid_o,
  output logic                                   out_tlast_o,
  input  logic                                   out_tready_i,
  input  logic [CHANNEL_NUMBER*WEIGHT_WIDTH-1:0] weight_i,
  output logic [CHANNEL_NUMBER_WIDTH-1:0]        current_grant_o,
  output logic [XW-1:0]                          target_x_o,
  output logic [YW-1:0]                          target_y_o,
  output logic                                   busy_o,
  output logic                                   proto_err_o
);

  localparam int LEN_LSB = 2 * (XW + YW);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, BUSY = 2'd2} state_t;

  state_t                          state_r;
  logic [CHANNEL_NUMBER_WIDTH-1:0] ptr_r;
  logic [WEIGHT_WIDTH-1:0]         credit_r;
  logic [CHANNEL_NUMBER_WIDTH-1:0] lock_ch_r;
  logic [LENGTH_WIDTH-1:0]         beats_left_r;
  logic [XW-1:0]                   tx_r;
  logic [YW-1:0]                   ty_r;

  logic [CHANNEL_NUMBER_WIDTH-1:0] sel_s;
  logic [CHANNEL_NUMBER_WIDTH-1:0] grant_s;
  logic [CHANNEL_NUMBER_WIDTH-1:0] ptr_nxt_s;
  logic [LENGTH_WIDTH-1:0]         len_s;
  logic                            hs_s;
  logic                            hdr_s;
  logic                            multi_s;
  logic                            last_s;
  logic                            done_s;
  logic                            err_s;

  function automatic int wrap(input int v);
    return (v >= CHANNEL_NUMBER) ? (v - CHANNEL_NUMBER) : v;
  endfunction

  // A zero weight still grants one packet per turn.
  function automatic logic [WEIGHT_WIDTH-1:0] at_least_one(input logic [WEIGHT_WIDTH-1:0] w);
    return (w == '0) ? WEIGHT_WIDTH'(1) : w;
  endfunction

  // Round-robin candidate: scanning downwards leaves the nearest valid channel at or after ptr.
  always_comb begin
    sel_s = ptr_r;
    for (int k = CHANNEL_NUMBER - 1; k >= 0; k--) begin
      sel_s = in_tvalid_i[wrap(int'(ptr_r) + k)] ? CHANNEL_NUMBER_WIDTH'(wrap(int'(ptr_r) + k)) : sel_s;
    end
  end

  // Grant selection and the zero-latency stream multiplexer.
  always_comb begin
    grant_s      = (state_r == IDLE) ? sel_s : lock_ch_r;
    out_tvalid_o = in_tvalid_i[grant_s];
    out_tdata_o  = in_tdata_i[grant_s*DATA_WIDTH +: DATA_WIDTH];
    out_tid_o    = in_tid_i[grant_s*ID_WIDTH +: ID_WIDTH];
    out_tlast_o  = in_tlast_i[grant_s];
    in_tready_o  = '0;
    in_tready_o[grant_s] = out_tready_i;
  end

  // Beat decode, packet completion and status outputs.
  always_comb begin
    hdr_s     = out_tvalid_o && (out_tid_o == ID_WIDTH'(ROUTING_HEADER_ID));
    len_s     = out_tdata_o[LEN_LSB +: LENGTH_WIDTH];
    hs_s      = out_tvalid_o && out_tready_i;
    multi_s   = (FRAMING == 0) ? (len_s >= LENGTH_WIDTH'(2)) : !out_tlast_o;
    last_s    = (FRAMING == 0) ? (beats_left_r == LENGTH_WIDTH'(1)) : out_tlast_o;
    done_s    = hs_s && ((state_r == BUSY) ? last_s : !(hdr_s && multi_s));
    err_s     = hs_s && (state_r != BUSY) && (!hdr_s || ((FRAMING == 0) && (len_s == '0)));
    ptr_nxt_s = (grant_s == CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1)) ? '0
                                                                       : grant_s + CHANNEL_NUMBER_WIDTH'(1);
    target_x_o      = hdr_s ? out_tdata_o[YW +: XW] : tx_r;
    target_y_o      = hdr_s ? out_tdata_o[0 +: YW] : ty_r;
    proto_err_o     = err_s && !rst_i;
    busy_o          = (state_r != IDLE);
    current_grant_o = grant_s;
  end

  // Ownership FSM, weighted credit bookkeeping and coordinate latch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      ptr_r        <= '0;
      credit_r     <= at_least_one(weight_i[0 +: WEIGHT_WIDTH]);
      lock_ch_r    <= '0;
      beats_left_r <= '0;
      tx_r         <= '0;
      ty_r         <= '0;
    end else begin
      if (done_s) begin
        if ((grant_s == ptr_r) && (credit_r > WEIGHT_WIDTH'(1))) begin
          credit_r <= credit_r - WEIGHT_WIDTH'(1);
        end else begin
          ptr_r    <= ptr_nxt_s;
          credit_r <= at_least_one(weight_i[ptr_nxt_s*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
        end
      end
      case (state_r)
        IDLE, HOLD: begin
          if (hs_s) begin
            if (hdr_s) begin
              tx_r <= out_tdata_o[YW +: XW];
              ty_r <= out_tdata_o[0 +: YW];
            end
            if (hdr_s && multi_s) begin
              state_r      <= BUSY;
              lock_ch_r    <= grant_s;
              beats_left_r <= len_s - LENGTH_WIDTH'(1);
            end else begin
              state_r <= IDLE;
            end
          end else if (out_tvalid_o) begin
            state_r   <= HOLD;
            lock_ch_r <= grant_s;
          end
        end
        BUSY: begin
          if (hs_s) begin
            beats_left_r <= beats_left_r - LENGTH_WIDTH'(1);
            if (last_s) begin
              state_r <= IDLE;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_wrr_arbiter.sv
// Bench for packet_wrr_arbiter: two instances (length framing and TLAST framing) driven by per-channel
// beat queues and checked every cycle against a packet-level ownership/credit model, plus directed scenarios.
module tb_packet_wrr_arbiter;

  localparam int N  = 5;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int WW = 4;
  localparam int CW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  logic            clk;
  logic            rst;
  logic [N-1:0]    tv   [2];
  logic [N*DW-1:0] td   [2];
  logic [N*IW-1:0] ti   [2];
  logic [N-1:0]    tl   [2];
  logic [N-1:0]    trdy [2];
  logic            ov   [2];
  logic [DW-1:0]   od   [2];
  logic [IW-1:0]   oi   [2];
  logic            ol   [2];
  logic            ordy [2];
  logic [N*WW-1:0] w    [2];
  logic [CW-1:0]   cg   [2];
  logic [1:0]      tx   [2];
  logic [1:0]      ty   [2];
  logic            busy [2];
  logic            perr [2];

  beat_t     q [2*N][$];
  bit [N-1:0] pres [2];
  int        vprob;
  int        rprob;
  int        errors;
  int        checks;

  // model state: owning channel (-1 = free), packet progress, turn pointer and credit
  int  m_ptr [2], m_credit [2], m_lock [2], m_done [2], m_total [2], m_tx [2], m_ty [2];
  bit  m_inpkt [2];
  // what the model saw in the current cycle
  int  e_g [2], e_len [2];
  bit  e_hs [2], e_ov [2], e_hdr [2], e_last [2];
  logic [DW-1:0] e_dd [2];
  // DUT values sampled in the current cycle, for the directed scenarios
  int  obs_g [2], obs_busy [2], obs_perr [2], obs_data [2];

  packet_wrr_arbiter #(.FRAMING(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .in_tvalid_i(tv[0]), .in_tdata_i(td[0]), .in_tid_i(ti[0]),
    .in_tlast_i(tl[0]), .in_tready_o(trdy[0]), .out_tvalid_o(ov[0]), .out_tdata_o(od[0]),
    .out_tid_o(oi[0]), .out_tlast_o(ol[0]), .out_tready_i(ordy[0]), .weight_i(w[0]),
    .current_grant_o(cg[0]), .target_x_o(tx[0]), .target_y_o(ty[0]), .busy_o(busy[0]),
    .proto_err_o(perr[0])
  );

  packet_wrr_arbiter #(.FRAMING(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_tvalid_i(tv[1]), .in_tdata_i(td[1]), .in_tid_i(ti[1]),
    .in_tlast_i(tl[1]), .in_tready_o(trdy[1]), .out_tvalid_o(ov[1]), .out_tdata_o(od[1]),
    .out_tid_o(oi[1]), .out_tlast_o(ol[1]), .out_tready_i(ordy[1]), .weight_i(w[1]),
    .current_grant_o(cg[1]), .target_x_o(tx[1]), .target_y_o(ty[1]), .busy_o(busy[1]),
    .proto_err_o(perr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[dut%0d] at %0t: got 0x%0h expected 0x%0h", nm, d, $time, act, exp);
    end
  endtask

  function automatic int wmax(input int d, input int c);
    int v;
    v = int'(w[d][c*WW +: WW]);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int model_sel(input int d);
    if (m_lock[d] >= 0) return m_lock[d];
    for (int k = 0; k < N; k++) begin
      if (tv[d][(m_ptr[d] + k) % N]) return (m_ptr[d] + k) % N;
    end
    return m_ptr[d];
  endfunction

  task automatic complete(input int d, input int c);
    if (c == m_ptr[d] && m_credit[d] > 1) begin
      m_credit[d]--;
    end else begin
      m_ptr[d]    = (c + 1) % N;
      m_credit[d] = wmax(d, m_ptr[d]);
    end
  endtask

  task automatic model_update(input int d);
    bit multi;
    if (rst) begin
      m_ptr[d] = 0; m_credit[d] = wmax(d, 0); m_lock[d] = -1;
      m_inpkt[d] = 1'b0; m_tx[d] = 0; m_ty[d] = 0;
    end else if (e_hs[d]) begin
      if (m_inpkt[d]) begin
        m_done[d]++;
        if ((d == 0) ? (m_done[d] >= m_total[d]) : e_last[d]) begin
          complete(d, e_g[d]);
          m_inpkt[d] = 1'b0; m_lock[d] = -1;
        end
      end else begin
        multi = 1'b0;
        if (e_hdr[d]) begin
          m_tx[d] = int'(e_dd[d][3:2]);
          m_ty[d] = int'(e_dd[d][1:0]);
          m_total[d] = (e_len[d] == 0) ? 1 : e_len[d];
          multi = (d == 0) ? (m_total[d] >= 2) : !e_last[d];
        end
        if (multi) begin
          m_inpkt[d] = 1'b1; m_lock[d] = e_g[d]; m_done[d] = 1;
        end else begin
          complete(d, e_g[d]);
          m_lock[d] = -1;
        end
      end
    end else if (e_ov[d] && !m_inpkt[d]) begin
      m_lock[d] = e_g[d];
    end
  endtask

  // One clock cycle: drive sources, check every output at the falling edge, advance model at the rising edge.
  task automatic step(input bit do_chk);
    int g, qi, exp_tr;
    bit pe;
    logic [DW-1:0] dd;
    logic [IW-1:0] id;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < N; c++) begin
        qi = d*N + c;
        if (!pres[d][c] && q[qi].size() > 0 && $urandom_range(99) < vprob) pres[d][c] = 1'b1;
        if (pres[d][c]) begin
          tv[d][c] = 1'b1;
          td[d][c*DW +: DW] = q[qi][0].data;
          ti[d][c*IW +: IW] = q[qi][0].id;
          tl[d][c] = q[qi][0].last;
        end else begin
          tv[d][c] = 1'b0;
          td[d][c*DW +: DW] = $urandom;
          ti[d][c*IW +: IW] = IW'($urandom);
          tl[d][c] = 1'($urandom);
        end
      end
      ordy[d] = ($urandom_range(99) < rprob);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      g  = model_sel(d);
      dd = td[d][g*DW +: DW];
      id = ti[d][g*IW +: IW];
      e_g[d] = g; e_dd[d] = dd; e_ov[d] = tv[d][g]; e_last[d] = tl[d][g];
      e_hdr[d] = e_ov[d] && (id == 4'd0);
      e_len[d] = int'(dd[15:8]);
      e_hs[d]  = e_ov[d] && ordy[d];
      pe = e_hs[d] && !rst && !m_inpkt[d] && (!e_hdr[d] || (d == 0 && e_len[d] == 0));
      exp_tr = ordy[d] ? (1 << g) : 0;
      if (do_chk) begin
        chk("grant", d, int'(cg[d]), g);
        chk("tvalid", d, int'(ov[d]), int'(e_ov[d]));
        chk("tdata", d, int'(od[d]), int'(dd));
        chk("tid", d, int'(oi[d]), int'(id));
        chk("tlast", d, int'(ol[d]), int'(e_last[d]));
        chk("tready", d, int'(trdy[d]), exp_tr);
        chk("target_x", d, int'(tx[d]), e_hdr[d] ? int'(dd[3:2]) : m_tx[d]);
        chk("target_y", d, int'(ty[d]), e_hdr[d] ? int'(dd[1:0]) : m_ty[d]);
        chk("busy", d, int'(busy[d]), int'(m_lock[d] >= 0));
        chk("proto_err", d, int'(perr[d]), int'(pe));
      end
      obs_g[d] = int'(cg[d]); obs_busy[d] = int'(busy[d]);
      obs_perr[d] = int'(perr[d]); obs_data[d] = int'(od[d]);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      model_update(d);
      if (e_hs[d]) begin
        void'(q[d*N + e_g[d]].pop_front());
        pres[d][e_g[d]] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic push_pkt(input int d, input int c, input int x, input int y, input int len, input int nb);
    beat_t b;
    logic [DW-1:0] hd;
    hd = $urandom;
    hd[15:8] = 8'(len);
    hd[3:2]  = 2'(x);
    hd[1:0]  = 2'(y);
    b.data = hd; b.id = 4'd0; b.last = (nb == 1);
    q[d*N + c].push_back(b);
    for (int i = 1; i < nb; i++) begin
      b.data = $urandom; b.id = 4'($urandom_range(15, 1)); b.last = (i == nb - 1);
      q[d*N + c].push_back(b);
    end
  endtask

  task automatic push_stray(input int d, input int c);
    beat_t b;
    b.data = $urandom; b.id = 4'($urandom_range(15, 1)); b.last = 1'($urandom);
    q[d*N + c].push_back(b);
  endtask

  task automatic rand_pkt(input int d, input int c);
    int len, nb;
    if ($urandom_range(99) < 10) begin
      push_stray(d, c);
    end else begin
      len = $urandom_range(5, 0);
      nb  = (d == 0) ? ((len == 0) ? 1 : len) : $urandom_range(5, 1);
      push_pkt(d, c, $urandom_range(3, 0), $urandom_range(3, 0), len, nb);
    end
  endtask

  initial begin
    int p2 [6];
    logic [DW-1:0] h2;
    p2 = '{0, 0, 0, 1, 0, 1};
    errors = 0; checks = 0;
    vprob = 100; rprob = 100;
    pres[0] = '0; pres[1] = '0;
    w[0] = 20'h11111; w[1] = 20'h11111;
    rst = 1'b1;
    step(1'b0);
    step(1'b1);
    rst = 1'b0;
    chk("reset_busy", 0, obs_busy[0], 0);
    chk("reset_grant", 0, obs_g[0], 0);

    // all five channels stream 3-beat packets, weight 1: grants rotate every 3 beats
    for (int c = 0; c < N; c++) push_pkt(0, c, c % 4, 3 - (c % 4), 3, 3);
    push_pkt(0, 0, 1, 2, 3, 3);
    for (int k = 0; k < 18; k++) begin
      step(1'b1);
      chk("s1_grant", 0, obs_g[0], (k / 3) % 5);
      if (k % 3 != 0) chk("s1_busy", 0, obs_busy[0], 1);
    end

    // ch0 weight 3, ch1 weight 1, both streaming 2-beat packets
    w[0] = 20'h11113;
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) push_pkt(0, 0, 2, 1, 2, 2);
    for (int i = 0; i < 2; i++) push_pkt(0, 1, 3, 0, 2, 2);
    for (int k = 0; k < 12; k++) begin
      step(1'b1);
      chk("s2_grant", 0, obs_g[0], p2[k / 2]);
    end

    // ch2 header stalled by backpressure while ch3 becomes valid
    push_pkt(0, 2, 1, 1, 1, 1);
    step(1'b1);
    chk("s3_pre_grant", 0, obs_g[0], 2);
    rprob = 0;
    push_pkt(0, 2, 2, 3, 1, 1);
    h2 = q[2][0].data;
    for (int k = 0; k < 4; k++) begin
      step(1'b1);
      chk("s3_hold_grant", 0, obs_g[0], 2);
      chk("s3_hold_data", 0, obs_data[0], int'(h2));
      if (k == 0) push_pkt(0, 3, 0, 2, 1, 1);
    end
    rprob = 100;
    step(1'b1);
    chk("s3_hs_grant", 0, obs_g[0], 2);
    chk("s3_hs_data", 0, obs_data[0], int'(h2));
    step(1'b1);
    chk("s3_next_grant", 0, obs_g[0], 3);

    // TLAST framing: 5-beat packet whose length field says 2
    push_pkt(1, 1, 3, 3, 2, 5);
    step(1'b1);
    chk("s4_first_grant", 1, obs_g[1], 1);
    push_pkt(1, 2, 0, 1, 1, 1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1);
      chk("s4_lock_grant", 1, obs_g[1], 1);
      chk("s4_lock_busy", 1, obs_busy[1], 1);
    end
    step(1'b1);
    chk("s4_release_grant", 1, obs_g[1], 2);
    chk("s4_release_busy", 1, obs_busy[1], 0);

    // zero-length header then a non-header beat, both in IDLE
    push_pkt(0, 4, 1, 0, 0, 1);
    push_stray(0, 4);
    for (int k = 0; k < 2; k++) begin
      step(1'b1);
      chk("s5_grant", 0, obs_g[0], 4);
      chk("s5_perr", 0, obs_perr[0], 1);
      chk("s5_busy", 0, obs_busy[0], 0);
    end
    step(1'b1);
    chk("s5_quiet_perr", 0, obs_perr[0], 0);

    // reset on beat 2 of a 6-beat packet
    push_pkt(0, 2, 3, 1, 6, 6);
    step(1'b1);
    chk("s6_hdr_perr", 0, obs_perr[0], 0);
    rst = 1'b1;
    step(1'b1);
    chk("s6_rst_perr", 0, obs_perr[0], 0);
    rst = 1'b0;
    step(1'b1);
    chk("s6_after_busy", 0, obs_busy[0], 0);
    chk("s6_after_perr", 0, obs_perr[0], 1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      chk("s6_tail_perr", 0, obs_perr[0], 1);
    end

    // randomized traffic, weights, backpressure and occasional resets
    vprob = 60; rprob = 70;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(99) < 25) begin
          int c;
          c = $urandom_range(N - 1, 0);
          if (q[d*N + c].size() < 8) rand_pkt(d, c);
        end
        if ($urandom_range(99) == 0) w[d] = 20'($urandom);
      end
      rst = ($urandom_range(999) < 2);
      step(1'b1);
    end
    rst = 1'b0; vprob = 100; rprob = 100;
    for (int k = 0; k < 200; k++) step(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
